stopwatch_core: RTL and testbench
=================================

// Module: stopwatch_core
// PURPOSE
//  Stopwatch timebase, control FSM and digit encoder feeding the 4-digit display controller.
//  Counts MM:SS in BCD from clk_100hz and handles start/pause, lap and clear commands.
//  Drives four active-low 7-segment patterns plus lap_or_not (1 = display follows live time, 0 = display holds).
// PARAMETERS
//  TICKS_PER_SEC  100  clk_100hz cycles per counted second (>=2)
// PORTS
//  clk_100hz   in   1  system clock, 100 Hz
//  rst         in   1  asynchronous, active-low reset
//  start_pulse in   1  one-cycle pulse (already debounced): start/pause toggle
//  lap_pulse   in   1  one-cycle pulse (already debounced): lap toggle (RUN) / clear (IDLE, PAUSE)
//  sec0_dec    out  8  seconds-units segment pattern {a,b,c,d,e,f,g,dp}, active-low
//  sec1_dec    out  8  seconds-tens segment pattern
//  min0_dec    out  8  minutes-units segment pattern
//  min1_dec    out  8  minutes-tens segment pattern
//  lap_or_not  out  1  1 = live, 0 = lap frozen
//  running     out  1  1 while FSM in RUN
//  sec_tick    out  1  one-cycle pulse on each counted-second increment
// BEHAVIOUR
//  Reset (rst=0, async): FSM=IDLE, prescaler=0, BCD digits all 0, lap_or_not=1, running=0,
//   sec_tick=0; all *_dec = 8'b00000011 ('0').
//  FSM states and transitions (evaluated each clk_100hz edge):
//   IDLE : start_pulse -> RUN. lap_pulse alone -> clear (stays IDLE).
//   RUN  : start_pulse -> PAUSE. lap_pulse alone -> toggle lap_or_not.
//   PAUSE: start_pulse -> RUN. lap_pulse alone -> clear, -> IDLE.
//   clear: prescaler=0, digits=00:00, lap_or_not=1, in same edge.
//   start_pulse and lap_pulse in same cycle: start_pulse wins, lap_pulse ignored.
//   lap_or_not is left unchanged by RUN<->PAUSE, so a frozen lap persists across pause.
//  Prescaler: counts 0..TICKS_PER_SEC-1 only in RUN; holds its value in PAUSE (not reset).
//   The edge where prescaler==TICKS_PER_SEC-1 in RUN: prescaler->0, seconds increment, and
//   sec_tick=1 for the following cycle (registered).
//   Entering RUN resumes from the held prescaler value.
//  BCD counting: sec0 0..9, sec1 0..5, min0 0..9, min1 0..5; carry ripples in same edge.
//   59:59 + 1 s -> 00:00 (wrap, no saturation, FSM stays RUN).
//  Encoding: combinational from registered digits; zero added latency.
//   0=00000011 1=10011111 2=00100101 3=00001101 4=10011001
//   5=01001001 6=01000001 7=00011111 8=00000001 9=00001001; dp always 1 (off).
//   Unreachable codes (10..15) -> 11111111 (blank).
//  running = (state==RUN), registered with state.
//  Reset asserted mid-count or mid-lap: immediate return to reset values; no pending commands kept.
// TESTING
//  1. Reset, start_pulse, run 100 cycles -> sec0_dec=10011111 ('1'), one sec_tick pulse, running=1.
//  2. Run to 59:59, then 100 more cycles -> all digits 00000011, FSM still RUN, lap_or_not=1.
//  3. At 00:05 plus 40 cycles, start_pulse; wait 500 cycles; start_pulse -> resume, 00:06 after 60 more cycles.
//  4. In RUN, lap_pulse -> lap_or_not=0 next edge. Second lap_pulse -> 1. Digits keep counting throughout.
//  5. PAUSE at 00:07 with lap_or_not=0, lap_pulse -> 00:00, lap_or_not=1, IDLE, prescaler=0.
//  6. start_pulse and lap_pulse same cycle in RUN -> PAUSE, lap_or_not unchanged. Then rst low mid-count -> all reset values asynchronously.

Source files
------------

// File: rtl/stopwatch_core.sv
// Stopwatch core: 100 Hz prescaler, start/pause/lap control FSM, MM:SS BCD counter
// and active-low 7-segment encoders for the four display digits.
//
// state | meaning
// IDLE  | stopped at a cleared time, waiting for start
// RUN   | prescaler and BCD digits advancing
// PAUSE | counting frozen, prescaler phase held for resume
module stopwatch_core #(
  parameter int TICKS_PER_SEC = 100
) (
  input  logic       clk_100hz,
  input  logic       rst,
  input  logic       start_pulse,
  input  logic       lap_pulse,
  output logic [7:0] sec0_dec,
  output logic [7:0] sec1_dec,
  output logic [7:0] min0_dec,
  output logic [7:0] min1_dec,
  output logic       lap_or_not,
  output logic       running,
  output logic       sec_tick
);

  localparam int PW = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICKS_PER_SEC - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2
  } state_t;

  state_t        state, next_state;
  logic [PW-1:0] prescaler;
  logic [3:0]    sec0, sec1, min0, min1;
  logic          do_clear;
  logic          do_lap_toggle;
  logic          do_count;
  logic          wrap_sec;

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      running <= 1'b0;
    end else begin
      state   <= next_state;
      running <= (next_state == RUN);
    end
  end

  // start_pulse has priority; lap_pulse only acts when start_pulse is low
  always_comb begin
    next_state    = state;
    do_clear      = 1'b0;
    do_lap_toggle = 1'b0;
    case (state)
      IDLE: begin
        if (start_pulse)    next_state = RUN;
        else if (lap_pulse) do_clear = 1'b1;
      end
      RUN: begin
        if (start_pulse)    next_state = PAUSE;
        else if (lap_pulse) do_lap_toggle = 1'b1;
      end
      PAUSE: begin
        if (start_pulse) begin
          next_state = RUN;
        end else if (lap_pulse) begin
          do_clear   = 1'b1;
          next_state = IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // The edge that leaves RUN does not advance the prescaler, so a pause freezes its phase.
  assign do_count = (state == RUN) && (next_state == RUN);
  assign wrap_sec = do_count && (prescaler == PRE_LAST);

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      prescaler <= '0;
      sec_tick  <= 1'b0;
    end else begin
      sec_tick <= wrap_sec;
      if (do_clear || wrap_sec) prescaler <= '0;
      else if (do_count)        prescaler <= prescaler + 1'b1;
    end
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst) begin
      sec0 <= 4'd0;
      sec1 <= 4'd0;
      min0 <= 4'd0;
      min1 <= 4'd0;
    end else if (do_clear) begin
      sec0 <= 4'd0;
      sec1 <= 4'd0;
      min0 <= 4'd0;
      min1 <= 4'd0;
    end else if (wrap_sec) begin
      if (sec0 == 4'd9) begin
        sec0 <= 4'd0;
        if (sec1 == 4'd5) begin
          sec1 <= 4'd0;
          if (min0 == 4'd9) begin
            min0 <= 4'd0;
            if (min1 == 4'd5) min1 <= 4'd0;
            else              min1 <= min1 + 4'd1;
          end else begin
            min0 <= min0 + 4'd1;
          end
        end else begin
          sec1 <= sec1 + 4'd1;
        end
      end else begin
        sec0 <= sec0 + 4'd1;
      end
    end
  end

  always_ff @(posedge clk_100hz or negedge rst) begin
    if (!rst)               lap_or_not <= 1'b1;
    else if (do_clear)      lap_or_not <= 1'b1;
    else if (do_lap_toggle) lap_or_not <= ~lap_or_not;
  end

  function automatic logic [7:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 8'b00000011;
      4'd1:    seg7 = 8'b10011111;
      4'd2:    seg7 = 8'b00100101;
      4'd3:    seg7 = 8'b00001101;
      4'd4:    seg7 = 8'b10011001;
      4'd5:    seg7 = 8'b01001001;
      4'd6:    seg7 = 8'b01000001;
      4'd7:    seg7 = 8'b00011111;
      4'd8:    seg7 = 8'b00000001;
      4'd9:    seg7 = 8'b00001001;
      default: seg7 = 8'b11111111;
    endcase
  endfunction

  assign sec0_dec = seg7(sec0);
  assign sec1_dec = seg7(sec1);
  assign min0_dec = seg7(min0);
  assign min1_dec = seg7(min1);

endmodule

// File: tb/tb_stopwatch_core.sv
// Bench for stopwatch_core: command table, directed corner sequences and random
// start/lap traffic compared against a seconds-counting reference model.
module tb_stopwatch_core;

  localparam int TPS = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2;

  logic       clk_100hz = 1'b0;
  logic       rst = 1'b0;
  logic       start_pulse = 1'b0;
  logic       lap_pulse = 1'b0;
  logic [7:0] sec0_dec, sec1_dec, min0_dec, min1_dec;
  logic       lap_or_not, running, sec_tick;

  stopwatch_core #(.TICKS_PER_SEC(TPS)) dut (
    .clk_100hz  (clk_100hz),
    .rst        (rst),
    .start_pulse(start_pulse),
    .lap_pulse  (lap_pulse),
    .sec0_dec   (sec0_dec),
    .sec1_dec   (sec1_dec),
    .min0_dec   (min0_dec),
    .min1_dec   (min1_dec),
    .lap_or_not (lap_or_not),
    .running    (running),
    .sec_tick   (sec_tick)
  );

  always #5 clk_100hz = ~clk_100hz;

  logic [7:0] seg_tab [0:9] = '{8'b00000011, 8'b10011111, 8'b00100101, 8'b00001101,
                                8'b10011001, 8'b01001001, 8'b01000001, 8'b00011111,
                                8'b00000001, 8'b00001001};

  int tests = 0;
  int fails = 0;

  // Reference model: elapsed whole seconds, prescaler phase, mode, lap flag, tick
  int m_mode, m_pre, m_secs;
  bit m_lap, m_tick;

  typedef struct packed {
    logic sp;
    logic lp;
    logic exp_run;
    logic exp_lap;
  } vec_t;
  vec_t tab [0:13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_mode = M_IDLE; m_pre = 0; m_secs = 0; m_lap = 1; m_tick = 0;
  endtask

  task automatic model_edge(input logic sp, input logic lp);
    m_tick = 0;
    if (sp) begin
      m_mode = (m_mode == M_RUN) ? M_PAUSE : M_RUN;
    end else begin
      if (m_mode == M_RUN) begin
        m_pre++;
        if (m_pre == TPS) begin
          m_pre  = 0;
          m_secs = (m_secs + 1) % 3600;
          m_tick = 1;
        end
        if (lp) m_lap = !m_lap;
      end else if (lp) begin
        m_mode = M_IDLE; m_pre = 0; m_secs = 0; m_lap = 1;
      end
    end
  endtask

  task automatic check_model(input string tag);
    chk({tag, "_sec0"}, sec0_dec, seg_tab[m_secs % 10]);
    chk({tag, "_sec1"}, sec1_dec, seg_tab[(m_secs / 10) % 6]);
    chk({tag, "_min0"}, min0_dec, seg_tab[(m_secs / 60) % 10]);
    chk({tag, "_min1"}, min1_dec, seg_tab[m_secs / 600]);
    chk({tag, "_run"}, running, (m_mode == M_RUN));
    chk({tag, "_lap"}, lap_or_not, m_lap);
    chk({tag, "_tick"}, sec_tick, m_tick);
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_sec0"}, sec0_dec, 8'b00000011);
    chk({tag, "_sec1"}, sec1_dec, 8'b00000011);
    chk({tag, "_min0"}, min0_dec, 8'b00000011);
    chk({tag, "_min1"}, min1_dec, 8'b00000011);
    chk({tag, "_run"}, running, 0);
    chk({tag, "_lap"}, lap_or_not, 1);
    chk({tag, "_tick"}, sec_tick, 0);
  endtask

  task automatic step(input logic sp, input logic lp);
    start_pulse = sp;
    lap_pulse   = lp;
    @(posedge clk_100hz);
    model_edge(sp, lp);
    @(negedge clk_100hz);
    start_pulse = 0;
    lap_pulse   = 0;
  endtask

  task automatic idle_steps(input int n);
    for (int i = 0; i < n; i++) step(0, 0);
  endtask

  task automatic apply_reset();
    @(negedge clk_100hz);
    rst = 0;
    model_reset();
    #1 check_reset_vals("reset");
    @(negedge clk_100hz);
    rst = 1;
  endtask

  initial begin
    int ticks;
    int guard;

    tab[0]  = '{1'b0, 1'b1, 1'b0, 1'b1};   // clear in IDLE
    tab[1]  = '{1'b1, 1'b0, 1'b1, 1'b1};   // start
    tab[2]  = '{1'b0, 1'b1, 1'b1, 1'b0};   // lap freeze
    tab[3]  = '{1'b0, 1'b0, 1'b1, 1'b0};
    tab[4]  = '{1'b1, 1'b0, 1'b0, 1'b0};   // pause keeps lap
    tab[5]  = '{1'b1, 1'b0, 1'b1, 1'b0};   // resume keeps lap
    tab[6]  = '{1'b0, 1'b1, 1'b1, 1'b1};   // lap release
    tab[7]  = '{1'b1, 1'b1, 1'b0, 1'b1};   // both: start wins
    tab[8]  = '{1'b0, 1'b1, 1'b0, 1'b1};   // clear from PAUSE
    tab[9]  = '{1'b1, 1'b1, 1'b1, 1'b1};   // both in IDLE: start
    tab[10] = '{1'b0, 1'b1, 1'b1, 1'b0};
    tab[11] = '{1'b1, 1'b1, 1'b0, 1'b0};   // both in RUN, frozen lap kept
    tab[12] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tab[13] = '{1'b0, 1'b1, 1'b0, 1'b1};   // clear from PAUSE releases lap

    // Command table
    apply_reset();
    for (int i = 0; i < 14; i++) begin
      step(tab[i].sp, tab[i].lp);
      chk($sformatf("tab%0d_run", i), running, tab[i].exp_run);
      chk($sformatf("tab%0d_lap", i), lap_or_not, tab[i].exp_lap);
      check_model($sformatf("tab%0d", i));
    end

    // First second after start, single tick
    apply_reset();
    step(1, 0);
    ticks = 0;
    for (int i = 0; i < TPS - 1; i++) begin
      step(0, 0);
      if (sec_tick) ticks++;
    end
    chk("t1_sec0_before", sec0_dec, 8'b00000011);
    step(0, 0);
    if (sec_tick) ticks++;
    chk("t1_sec0", sec0_dec, 8'b10011111);
    chk("t1_tick_now", sec_tick, 1);
    chk("t1_running", running, 1);
    step(0, 0);
    if (sec_tick) ticks++;
    chk("t1_tick_count", ticks, 1);

    // Wrap 59:59 -> 00:00
    apply_reset();
    step(1, 0);
    idle_steps(3599 * TPS);
    chk("t2_sec0_9", sec0_dec, 8'b00001001);
    chk("t2_sec1_5", sec1_dec, 8'b01001001);
    chk("t2_min0_9", min0_dec, 8'b00001001);
    chk("t2_min1_5", min1_dec, 8'b01001001);
    idle_steps(TPS);
    chk("t2_wrap_sec0", sec0_dec, 8'b00000011);
    chk("t2_wrap_sec1", sec1_dec, 8'b00000011);
    chk("t2_wrap_min0", min0_dec, 8'b00000011);
    chk("t2_wrap_min1", min1_dec, 8'b00000011);
    chk("t2_wrap_run", running, 1);
    chk("t2_wrap_lap", lap_or_not, 1);
    chk("t2_wrap_tick", sec_tick, 1);

    // Pause holds prescaler phase
    apply_reset();
    step(1, 0);
    idle_steps(5 * TPS + 4);
    step(1, 0);
    chk("t3_paused", running, 0);
    idle_steps(5 * TPS);
    chk("t3_hold_sec0", sec0_dec, 8'b01001001);
    step(1, 0);
    idle_steps(TPS - 5);
    chk("t3_still5", sec0_dec, 8'b01001001);
    step(0, 0);
    chk("t3_now6", sec0_dec, 8'b01000001);
    check_model("t3");

    // Lap toggles while counting, then clear from PAUSE
    apply_reset();
    step(1, 0);
    idle_steps(3 * TPS);
    step(0, 1);
    chk("t4_lap_frozen", lap_or_not, 0);
    for (int i = 0; i < 2 * TPS; i++) begin
      step(0, 0);
      check_model("t4");
    end
    step(0, 1);
    chk("t4_lap_live", lap_or_not, 1);
    step(0, 1);
    idle_steps(2 * TPS - 3);
    step(1, 0);
    chk("t5_sec0_7", sec0_dec, 8'b00011111);
    chk("t5_lap_frozen", lap_or_not, 0);
    chk("t5_paused", running, 0);
    step(0, 1);
    chk("t5_clr_sec0", sec0_dec, 8'b00000011);
    chk("t5_clr_lap", lap_or_not, 1);
    chk("t5_clr_idle", running, 0);
    step(1, 0);
    idle_steps(TPS - 1);
    chk("t5_pre0_still0", sec0_dec, 8'b00000011);
    step(0, 0);
    chk("t5_pre0_now1", sec0_dec, 8'b10011111);

    // Simultaneous pulses in RUN, then async reset mid-count
    apply_reset();
    step(1, 0);
    idle_steps(2 * TPS + 3);
    step(0, 1);
    step(1, 1);
    chk("t6_both_pause", running, 0);
    chk("t6_both_lap", lap_or_not, 0);
    step(1, 0);
    guard = 0;
    while (!m_tick && guard < 2 * TPS) begin
      step(0, 0);
      guard++;
    end
    chk("t6_tick_reached", m_tick, 1);
    check_model("t6_pre");
    #2 rst = 0;
    #1 check_reset_vals("t6_async");
    model_reset();
    @(negedge clk_100hz);
    rst = 1;

    // Random start/lap traffic
    for (int i = 0; i < 4000; i++) begin
      step(($urandom_range(0, 15) == 0), ($urandom_range(0, 11) == 0));
      check_model("rnd");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
